rd_seq: RTL and testbench

RD_SEQ -- requirements
Module: rd_seq

---
 rtl/ldpc_rd_pkg.sv | 22 ++
 rtl/rd_seq_out_addr_gen.sv | 38 +++
 rtl/rd_seq.sv | 183 ++++++++++++++++++
 tb/tb_rd_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_rd_pkg.sv
// rtl/ldpc_rd_pkg.sv - shared types and constants for the decoder read sequencer
//
// Purpose: state encoding, read sub-cycle codes and the default address width
// shared by rd_seq and its readout address generator.
// Ports: none (package).
package ldpc_rd_pkg;

  localparam int A_WID_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CYC_NONE = 2'b00;
  localparam logic [1:0] CYC_1    = 2'b01;
  localparam logic [1:0] CYC_2    = 2'b10;
  localparam logic [1:0] CYC_3    = 2'b11;

endpackage

// File: rtl/rd_seq_out_addr_gen.sv
// rtl/rd_seq_out_addr_gen.sv - readout address counter for rd_seq
//
// Purpose: counts readout addresses 0,1,...,len-1 under control of the
// sequencer FSM.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : return the counter to 0 (has priority over step)
//   step       : advance the counter by one
//   len        : number of readout addresses in the pass
//   addr       : current readout address
//   last       : addr is the final address of the pass (len-1)
module out_addr_gen
  import ldpc_rd_pkg::*;
#(
  parameter int A_WID = A_WID_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [A_WID-1:0] len,
  output logic [A_WID-1:0] addr,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= '0;
    end else if (step) begin
      addr <= addr + A_WID'(1);
    end
  end

  assign last = (addr == len - A_WID'(1));

endmodule

// File: rtl/rd_seq.sv
// rtl/rd_seq.sv - row/iteration read sequencer followed by a readout phase
//
// Purpose: on start, walks num_rows rows (three sub-cycles each) for
// iter_max iterations, then emits out_len readout addresses, then pulses done.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, abort, stall   : pass request, pass termination, sequencing freeze
//   base_start/row_stride : row 0 base address and per-row increment
//   num_rows, iter_max    : rows per iteration, iterations per pass (0 means 1)
//   out_len               : number of readout addresses
//   rd_en, cycle          : read phase flag and sub-cycle code
//   base_addr, row_idx    : current row base address and row number
//   out_en, out_addr      : readout phase flag and address
//   busy, done            : not idle; one-cycle normal completion pulse
module rd_seq
  import ldpc_rd_pkg::*;
#(
  parameter int A_WID = A_WID_DEF,
  parameter int R_WID = 6,
  parameter int I_WID = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic [A_WID-1:0] base_start,
  input  logic [A_WID-1:0] row_stride,
  input  logic [R_WID-1:0] num_rows,
  input  logic [I_WID-1:0] iter_max,
  input  logic [A_WID-1:0] out_len,
  output logic             rd_en,
  output logic [1:0]       cycle,
  output logic [A_WID-1:0] base_addr,
  output logic [R_WID-1:0] row_idx,
  output logic             out_en,
  output logic [A_WID-1:0] out_addr,
  output logic             busy,
  output logic             done
);

  state_t state, state_n;

  logic [A_WID-1:0] base_lat, stride_lat, len_lat;
  logic [R_WID-1:0] rows_lat;
  logic [I_WID-1:0] iter_lat, iter, iter_n;

  logic [1:0]       cyc_n;
  logic [A_WID-1:0] base_n;
  logic [R_WID-1:0] row_n;
  logic             cfg_ld, last_row, last_iter;
  logic             oa_load, oa_step, oa_last;

  assign last_row  = (row_idx == rows_lat - R_WID'(1));
  // A latched iteration count of zero behaves as a single iteration.
  assign last_iter = (iter_lat == '0) || (iter == iter_lat - I_WID'(1));

  always_comb begin
    state_n = state;
    cyc_n   = cycle;
    base_n  = base_addr;
    row_n   = row_idx;
    iter_n  = iter;
    cfg_ld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          cfg_ld = 1'b1;
          if (num_rows != '0) begin
            state_n = ST_READ;
            cyc_n   = CYC_1;
            base_n  = base_start;
            row_n   = '0;
            iter_n  = '0;
          end else if (out_len != '0) begin
            state_n = ST_OUT;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (!stall) begin
          if (cycle != CYC_3) begin
            cyc_n = cycle + 2'd1;
          end else if (!last_row) begin
            row_n  = row_idx + R_WID'(1);
            base_n = base_addr + row_stride_q();
            cyc_n  = CYC_1;
          end else if (!last_iter) begin
            // Next iteration starts back at row 0 with no gap cycle.
            iter_n = iter + I_WID'(1);
            row_n  = '0;
            base_n = base_lat;
            cyc_n  = CYC_1;
          end else begin
            state_n = (len_lat != '0) ? ST_OUT : ST_DONE;
          end
        end
      end
      ST_OUT: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (!stall && oa_last) begin
          state_n = ST_DONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // Row-side outputs read as zero whenever the next state is not a read.
    if (state_n != ST_READ) begin
      cyc_n  = CYC_NONE;
      base_n = '0;
      row_n  = '0;
      iter_n = '0;
    end
  end

  function automatic logic [A_WID-1:0] row_stride_q();
    return stride_lat;
  endfunction

  // The readout counter restarts at 0 on entry to OUT and sits at 0 elsewhere.
  assign oa_load = (state != ST_OUT) || (state_n != ST_OUT);
  assign oa_step = !oa_load && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle      <= CYC_NONE;
      base_addr  <= '0;
      row_idx    <= '0;
      iter       <= '0;
      base_lat   <= '0;
      stride_lat <= '0;
      len_lat    <= '0;
      rows_lat   <= '0;
      iter_lat   <= '0;
      rd_en      <= 1'b0;
      out_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cycle     <= cyc_n;
      base_addr <= base_n;
      row_idx   <= row_n;
      iter      <= iter_n;
      if (cfg_ld) begin
        base_lat   <= base_start;
        stride_lat <= row_stride;
        len_lat    <= out_len;
        rows_lat   <= num_rows;
        iter_lat   <= iter_max;
      end
      rd_en  <= (state_n == ST_READ);
      out_en <= (state_n == ST_OUT);
      busy   <= (state_n != ST_IDLE);
      done   <= (state_n == ST_DONE);
    end
  end

  out_addr_gen #(.A_WID(A_WID)) u_out_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (oa_load),
    .step  (oa_step),
    .len   (len_lat),
    .addr  (out_addr),
    .last  (oa_last)
  );

endmodule

// File: tb/tb_rd_seq.sv
// tb/tb_rd_seq.sv - self-checking bench for rd_seq
module tb_rd_seq;

  logic       clk = 1'b0;
  logic       reset, start, abort, stall;
  logic [7:0] base_start, row_stride, out_len;
  logic [5:0] num_rows;
  logic [3:0] iter_max;
  logic       rd_en, out_en, busy, done;
  logic [1:0] cycle;
  logic [7:0] base_addr, out_addr;
  logic [5:0] row_idx;

  always #5 clk = ~clk;

  rd_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
    .base_start(base_start), .row_stride(row_stride), .num_rows(num_rows),
    .iter_max(iter_max), .out_len(out_len), .rd_en(rd_en), .cycle(cycle),
    .base_addr(base_addr), .row_idx(row_idx), .out_en(out_en),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  typedef struct {
    logic       rd;
    logic [1:0] cyc;
    logic [7:0] base;
    logic [5:0] row;
    logic       oe;
    logic [7:0] oa;
    logic       dn;
  } exp_t;

  exp_t pass_q[$];
  int   m_pos = -1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  int   busy_cnt, done_cnt;
  int   rec_base[$];
  int   rec_cyc[$];
  int   rec_oa[$];

  // Whole pass laid out as the list of per-cycle outputs it must produce.
  function automatic void build_pass(input int bs, input int st, input int nr,
                                     input int im, input int ol);
    exp_t e;
    int   ni;
    ni = (im == 0) ? 1 : im;
    pass_q.delete();
    for (int it = 0; it < ni; it++)
      for (int r = 0; r < nr; r++)
        for (int c = 1; c <= 3; c++) begin
          e.rd = 1; e.cyc = 2'(c); e.base = 8'((bs + r * st) % 256); e.row = 6'(r);
          e.oe = 0; e.oa = 0; e.dn = 0;
          pass_q.push_back(e);
        end
    for (int a = 0; a < ol; a++) begin
      e.rd = 0; e.cyc = 0; e.base = 0; e.row = 0; e.oe = 1; e.oa = 8'(a); e.dn = 0;
      pass_q.push_back(e);
    end
    e.rd = 0; e.cyc = 0; e.base = 0; e.row = 0; e.oe = 0; e.oa = 0; e.dn = 1;
    pass_q.push_back(e);
  endfunction

  function automatic void model_step();
    if (reset) m_pos = -1;
    else if (m_pos < 0) begin
      if (start && !abort) begin
        build_pass(base_start, row_stride, num_rows, iter_max, out_len);
        m_pos = 0;
      end
    end else if (abort) m_pos = -1;
    else if (stall && !pass_q[m_pos].dn) m_pos = m_pos;
    else begin
      m_pos++;
      if (m_pos >= pass_q.size()) m_pos = -1;
    end
  endfunction

  function automatic logic [27:0] exp_vec();
    exp_t e;
    if (m_pos < 0) return 28'h0;
    e = pass_q[m_pos];
    return {e.rd, e.cyc, e.base, e.row, e.oe, e.oa, 1'b1, e.dn};
  endfunction

  function automatic logic [27:0] act_vec();
    return {rd_en, cycle, base_addr, row_idx, out_en, out_addr, busy, done};
  endfunction

  task automatic tick();
    logic [27:0] a, x;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en) begin
      a = act_vec();
      x = exp_vec();
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a, x);
      end
    end
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    if (rd_en) begin
      rec_base.push_back(int'(base_addr));
      rec_cyc.push_back(int'(cycle));
    end
    if (out_en) rec_oa.push_back(int'(out_addr));
  endtask

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0;
    rec_base.delete(); rec_cyc.delete(); rec_oa.delete();
  endtask

  task automatic launch(input int bs, input int st, input int nr, input int im, input int ol);
    base_start = 8'(bs); row_stride = 8'(st); num_rows = 6'(nr);
    iter_max = 4'(im); out_len = 8'(ol);
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit && busy; n++) tick();
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic check_q(input string nm, input int q[$], input int idx, input int req);
    check(nm, (idx < q.size()) ? q[idx] : -1, req);
  endtask

  initial begin
    int exp_b[6];
    int exp_c[6];
    int n;
    exp_b = '{16, 16, 16, 48, 48, 48};
    exp_c = '{1, 2, 3, 1, 2, 3};
    reset = 1; start = 0; abort = 0; stall = 0;
    base_start = 0; row_stride = 0; num_rows = 0; iter_max = 0; out_len = 0;
    tick();
    chk_en = 1;
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_vec", int'(act_vec()), 0);
    reset = 0;
    tick();

    // Two rows, one iteration, three readout addresses.
    clear_stats();
    launch(8'h10, 8'h20, 2, 1, 3);
    wait_idle(100);
    check("basic_rd_cycles", rec_base.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_q("basic_base", rec_base, i, exp_b[i]);
      check_q("basic_cyc", rec_cyc, i, exp_c[i]);
    end
    check("basic_out_cycles", rec_oa.size(), 3);
    for (int i = 0; i < 3; i++) check_q("basic_out_addr", rec_oa, i, i);
    check("basic_done", done_cnt, 1);
    check("basic_busy", busy_cnt, 10);

    // Two iterations, back-to-back reads.
    clear_stats();
    launch(8'h10, 8'h20, 2, 2, 3);
    wait_idle(100);
    check("iter2_rd_cycles", rec_base.size(), 12);
    check_q("iter2_base_c7", rec_base, 6, 8'h10);
    check("iter2_done", done_cnt, 1);
    check("iter2_busy", busy_cnt, 16);

    // Two-cycle stall at row 1 sub-cycle 10.
    clear_stats();
    launch(8'h10, 8'h20, 2, 1, 3);
    n = 0;
    while (n < 50 && !(rd_en && row_idx == 6'd1 && cycle == 2'b10)) begin tick(); n++; end
    check("stall_reach", n < 50 ? 1 : 0, 1);
    stall = 1;
    tick();
    tick();
    stall = 0;
    wait_idle(100);
    check("stall_busy", busy_cnt, 12);
    check("stall_rd_cycles", rec_base.size(), 8);
    check("stall_done", done_cnt, 1);

    // Abort during readout at address 1.
    clear_stats();
    launch(8'h10, 8'h20, 2, 1, 3);
    n = 0;
    while (n < 50 && !(out_en && out_addr == 8'd1)) begin tick(); n++; end
    check("abort_reach", n < 50 ? 1 : 0, 1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_vec", int'(act_vec()), 0);
    tick();
    tick();
    check("abort_done", done_cnt, 0);

    // Empty pass: straight to DONE.
    clear_stats();
    launch(8'h10, 8'h20, 0, 1, 0);
    wait_idle(10);
    check("empty_busy", busy_cnt, 1);
    check("empty_done", done_cnt, 1);
    check("empty_rd", rec_base.size() + rec_oa.size(), 0);

    // Base address wrap, then reset in the middle of a read.
    clear_stats();
    launch(8'hF0, 8'h20, 3, 1, 2);
    n = 0;
    while (n < 50 && !(rd_en && row_idx == 6'd1)) begin tick(); n++; end
    check("wrap_base", int'(base_addr), 8'h10);
    reset = 1;
    tick();
    reset = 0;
    check("midreset_vec", int'(act_vec()), 0);
    tick();

    // Randomized traffic against the pass model.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      abort = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      start = ($urandom_range(0, 3) == 0);
      base_start = 8'($urandom);
      row_stride = 8'($urandom);
      num_rows = 6'($urandom_range(0, 4));
      iter_max = 4'($urandom_range(0, 3));
      out_len = 8'($urandom_range(0, 5));
      tick();
    end
    reset = 0; abort = 0; stall = 0; start = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
